mac_seq_cu: RTL and testbench

Parametrised multiply/accumulate sequencing control unit. It drives the register file, the operand latches, the multiplier, the accumulator and the result RAM through a job of N operand pairs.

- A job is launched by a start pulse.
- Two modes: store every product to consecutive RAM addresses, or accumulate all products and store one sum.
- It sits between the top-level controls and the datapath (register file, multiplier, accumulator, RAM).
- It adds a handshake, abort, multiplier-latency waiting and address wrap-around to the fixed single-pair sequencer.

---
 rtl/mac_seq_cu.sv | 173 +++++++++++++++++
 tb/tb_mac_seq_cu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_cu.sv
// Multiply/accumulate sequencing control unit: walks N operand pairs through
// register-file reads, multiplier wait, and either per-product or summed RAM writes.
module mac_seq_cu #(
  parameter int ADR_W   = 3,
  parameter int RAM_AW  = 4,
  parameter int CNT_W   = 4,
  parameter int MUL_LAT = 1,
  parameter int ST_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADR_W-1:0]  adr1_base,
  input  logic [ADR_W-1:0]  adr2_base,
  input  logic [CNT_W-1:0]  n_pairs,
  input  logic [RAM_AW-1:0] ram_base,
  input  logic              abort,
  output logic [ADR_W-1:0]  rf_adr,
  output logic              w_rf,
  output logic              DA,
  output logic              mul_en,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              w_ram_en,
  output logic [RAM_AW-1:0] w_ram,
  output logic              ram_src,
  output logic              busy,
  output logic              done,
  output logic [ST_W-1:0]   st_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_MULT   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam int WW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MUL_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              mode_q, mode_d;
  logic [ADR_W-1:0]  a1_q, a1_d;
  logic [ADR_W-1:0]  a2_q, a2_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [RAM_AW-1:0] rb_q, rb_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      wait_q  <= '0;
      mode_q  <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      n_q     <= '0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      mode_q  <= mode_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      n_q     <= n_d;
      rb_q    <= rb_d;
    end
  end

  // Job parameters are captured once at launch; later input changes are ignored.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wait_d  = wait_q;
    mode_d  = mode_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    n_d     = n_q;
    rb_d    = rb_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mode_d  = mode;
          a1_d    = adr1_base;
          a2_d    = adr2_base;
          n_d     = n_pairs;
          rb_d    = ram_base;
          k_d     = '0;
          wait_d  = '0;
          state_d = (n_pairs == '0) ? S_DONE : S_LOAD_A;
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: begin
        wait_d  = '0;
        state_d = S_MULT;
      end
      S_MULT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_WRITE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WRITE: begin
        if (k_q == n_q - CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + CNT_W'(1);
          state_d = S_LOAD_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Moore outputs: abort only affects the next state, never the current cycle.
  always_comb begin
    rf_adr   = '0;
    w_rf     = 1'b0;
    DA       = 1'b0;
    mul_en   = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    w_ram_en = 1'b0;
    w_ram    = '0;
    ram_src  = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    st_out   = ST_W'(state_q);
    case (state_q)
      S_LOAD_A: begin
        rf_adr  = a1_q + ADR_W'(k_q);
        w_rf    = 1'b1;
        acc_clr = mode_q && (k_q == '0);
      end
      S_LOAD_B: begin
        rf_adr = a2_q + ADR_W'(k_q);
        w_rf   = 1'b1;
        DA     = 1'b1;
      end
      S_MULT: mul_en = 1'b1;
      S_WRITE: begin
        if (mode_q) begin
          acc_en = 1'b1;
        end else begin
          w_ram_en = 1'b1;
          w_ram    = rb_q + RAM_AW'(k_q);
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (mode_q && (n_q != '0)) begin
          w_ram_en = 1'b1;
          w_ram    = rb_q;
          ram_src  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac_seq_cu.sv
// Randomized and directed bench for mac_seq_cu against a cycle-trace reference
// model built from job parameters.
module tb_mac_seq_cu;

  localparam int ADR_W   = 3;
  localparam int RAM_AW  = 4;
  localparam int CNT_W   = 4;
  localparam int MUL_LAT = 1;
  localparam int ST_W    = 4;

  typedef struct packed {
    logic [ST_W-1:0]   st;
    logic [ADR_W-1:0]  rfAdr;
    logic              wRf;
    logic              da;
    logic              mulEn;
    logic              accClr;
    logic              accEn;
    logic              wRamEn;
    logic [RAM_AW-1:0] wRam;
    logic              ramSrc;
    logic              busy;
    logic              done;
  } outs_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, mode, abort;
  logic [ADR_W-1:0]  adr1_base, adr2_base;
  logic [CNT_W-1:0]  n_pairs;
  logic [RAM_AW-1:0] ram_base;
  logic [ADR_W-1:0]  rf_adr;
  logic              w_rf, DA, mul_en, acc_clr, acc_en, w_ram_en, ram_src, busy, done;
  logic [RAM_AW-1:0] w_ram;
  logic [ST_W-1:0]   st_out;

  int totalChecks = 0;
  int badChecks   = 0;
  outs_t expq[$];

  mac_seq_cu #(.ADR_W(ADR_W), .RAM_AW(RAM_AW), .CNT_W(CNT_W), .MUL_LAT(MUL_LAT), .ST_W(ST_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .adr1_base(adr1_base), .adr2_base(adr2_base), .n_pairs(n_pairs),
    .ram_base(ram_base), .abort(abort), .rf_adr(rf_adr), .w_rf(w_rf), .DA(DA),
    .mul_en(mul_en), .acc_clr(acc_clr), .acc_en(acc_en), .w_ram_en(w_ram_en),
    .w_ram(w_ram), .ram_src(ram_src), .busy(busy), .done(done), .st_out(st_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic outs_t getOuts();
    outs_t o;
    o = {st_out, rf_adr, w_rf, DA, mul_en, acc_clr, acc_en, w_ram_en, w_ram, ram_src, busy, done};
    return o;
  endfunction

  // Expected per-cycle trace of a job, starting at the cycle after start is sampled.
  function automatic void build(input bit m, input int a1, input int a2, input int n,
                                input int rb, input int abortAt);
    outs_t o;
    expq.delete();
    for (int k = 0; k < n; k++) begin
      o = '0; o.st = 1; o.busy = 1; o.wRf = 1;
      o.rfAdr = ADR_W'((a1 + k) % (1 << ADR_W));
      o.accClr = m && (k == 0);
      expq.push_back(o);
      o = '0; o.st = 2; o.busy = 1; o.wRf = 1; o.da = 1;
      o.rfAdr = ADR_W'((a2 + k) % (1 << ADR_W));
      expq.push_back(o);
      for (int w = 0; w < MUL_LAT; w++) begin
        o = '0; o.st = 3; o.busy = 1; o.mulEn = 1;
        expq.push_back(o);
      end
      o = '0; o.st = 4; o.busy = 1;
      if (m) o.accEn = 1;
      else begin
        o.wRamEn = 1;
        o.wRam = RAM_AW'((rb + k) % (1 << RAM_AW));
      end
      expq.push_back(o);
    end
    o = '0; o.st = 5; o.busy = 1; o.done = 1;
    if (m && n > 0) begin
      o.wRamEn = 1; o.wRam = RAM_AW'(rb); o.ramSrc = 1;
    end
    expq.push_back(o);
    if (abortAt > 0)
      while (expq.size() > abortAt) void'(expq.pop_back());
    o = '0;
    expq.push_back(o);
  endfunction

  task automatic scrambleInputs();
    mode      = 1'($urandom);
    adr1_base = ADR_W'($urandom);
    adr2_base = ADR_W'($urandom);
    n_pairs   = CNT_W'($urandom);
    ram_base  = RAM_AW'($urandom);
  endtask

  task automatic run_job(input string name, input bit m, input int a1, input int a2,
                         input int n, input int rb, input int abortAt, input int startAt);
    outs_t got;
    build(m, a1, a2, n, rb, abortAt);
    @(negedge clk);
    mode = m; adr1_base = ADR_W'(a1); adr2_base = ADR_W'(a2);
    n_pairs = CNT_W'(n); ram_base = RAM_AW'(rb);
    start = 1'b1; abort = 1'b0;
    for (int c = 1; c <= expq.size(); c++) begin
      @(negedge clk);
      got = getOuts();
      totalChecks++;
      if (got !== expq[c-1]) begin
        badChecks++;
        $display("[TB] FAIL %s cycle %0d: got %h (st=%0d) expected %h (st=%0d)",
                 name, c, got, got.st, expq[c-1], expq[c-1].st);
      end
      start = (c == startAt);
      abort = (c == abortAt);
      scrambleInputs();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    outs_t got;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    scrambleInputs();
    #1;
    got = getOuts();
    totalChecks++;
    if (got !== '0) begin
      badChecks++;
      $display("[TB] FAIL reset_state: got %h expected 0", got);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got = getOuts();
    totalChecks++;
    if (got !== '0) begin
      badChecks++;
      $display("[TB] FAIL idle_after_reset: got %h expected 0", got);
    end
  endtask

  task automatic test_mode0();
    run_job("mode0_n3", 1'b0, 1, 4, 3, 2, 0, 0);
  endtask

  task automatic test_mode1();
    run_job("mode1_n4", 1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 4, 7, 0, 0);
  endtask

  task automatic test_wrap();
    run_job("wrap", 1'b0, 6, int'($urandom_range(0, 7)), 3, 15, 0, 0);
  endtask

  task automatic test_zero_pairs();
    run_job("zero_m0", 1'b0, 3, 5, 0, 9, 0, 0);
    run_job("zero_m1", 1'b1, 3, 5, 0, 9, 0, 0);
  endtask

  task automatic test_abort();
    run_job("abort_mult_pair1", 1'b0, 2, 3, 3, 4, 3 + 4, 0);
    run_job("abort_in_write", 1'b0, 0, 0, 2, 1, 4, 0);
  endtask

  task automatic test_busy_start();
    run_job("busy_start", 1'b0, 1, 4, 3, 2, 0, 2);
  endtask

  task automatic test_start_abort_idle();
    outs_t got;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; n_pairs = 4'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      got = getOuts();
      totalChecks++;
      if (got !== '0) begin
        badChecks++;
        $display("[TB] FAIL start_abort_idle cycle %0d: got %h expected 0", c, got);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    outs_t got;
    build(1'b0, 1, 4, 3, 2, 0);
    @(negedge clk);
    mode = 1'b0; adr1_base = 3'd1; adr2_base = 3'd4; n_pairs = 4'd3; ram_base = 4'd2;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      got = getOuts();
      totalChecks++;
      if (got !== expq[c-1]) begin
        badChecks++;
        $display("[TB] FAIL pre_reset cycle %0d: got %h expected %h", c, got, expq[c-1]);
      end
    end
    #2 reset = 1'b0;
    #1;
    got = getOuts();
    totalChecks++;
    if (got !== '0) begin
      badChecks++;
      $display("[TB] FAIL async_reset_in_write: got %h expected 0", got);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      scrambleInputs();
      @(negedge clk);
      got = getOuts();
      totalChecks++;
      if (got !== '0) begin
        badChecks++;
        $display("[TB] FAIL idle_after_release cycle %0d: got %h expected 0", c, got);
      end
    end
  endtask

  task automatic test_random();
    int n, len, ab;
    for (int j = 0; j < 30; j++) begin
      n   = int'($urandom_range(0, 6));
      len = n * (3 + MUL_LAT) + 1;
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
      run_job($sformatf("random_%0d", j), 1'($urandom),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), n,
              int'($urandom_range(0, 15)), ab, 0);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_wrap();
    test_zero_pairs();
    test_abort();
    test_busy_start();
    test_start_abort_idle();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
